simd_issue_scheduler: RTL and testbench
=======================================

Name: simd_issue_scheduler

Overview:
- Distributes ALU instructions from the issue stage across NUM_SIMD simd instances using a round-robin policy.
- Enforces one outstanding instruction per SIMD by holding a busy bit from grant until that SIMD reports vgpr_instr_done.
- Collects per-SIMD completion pulses and serializes them onto a single retire port for the wavepool/scoreboard.

Parameters:
NUM_SIMD, 4, number of simd instances served (2..8)
SEL_W, 2, width of SIMD index, equals clog2(NUM_SIMD)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
issue_valid  input  1  issue stage presents an ALU instruction
issue_wfid  input  6  wavefront id of the presented instruction
issue_ready  output  1  scheduler accepts the instruction this cycle
simd_alu_ready  input  NUM_SIMD  per-SIMD issue_alu_ready
simd_alu_select  output  NUM_SIMD  one-hot, one-cycle issue_alu_select to the granted SIMD
simd_sel_wfid  output  6  wfid accompanying simd_alu_select
simd_instr_done  input  NUM_SIMD  per-SIMD vgpr_instr_done pulse
simd_instr_done_wfid  input  6*NUM_SIMD  per-SIMD vgpr_instr_done_wfid, SIMD i in bits [6i+5:6i]
retire_valid  output  1  one completion presented this cycle (pulse)
retire_wfid  output  6  wfid of the completion
retire_simd  output  SEL_W  index of the completing SIMD
busy  output  NUM_SIMD  per-SIMD outstanding flag
protocol_err  output  1  sticky error flag

Behaviour:
- Reset (async, rst=1): all outputs 0, busy=0, pending=0, grant pointer=0, retire pointer=0, protocol_err=0. A reset mid-operation drops all in-flight and pending state. No retire is produced for those entries.
- Eligibility: elig[i] = simd_alu_ready[i] & ~busy[i] & ~simd_alu_select[i]. All terms are registered state except simd_alu_ready.
- Ready rule: issue_ready = |elig. It is combinational, with no dependence on issue_valid.
- Accept: an accept occurs in cycle T when issue_valid & issue_ready.
  - The grant g is the first eligible index scanning from grant_ptr upward, wrapping at NUM_SIMD-1 to 0.
  - At the T edge: simd_alu_select <= onehot(g), simd_sel_wfid <= issue_wfid, busy[g] <= 1, grant_ptr <= (g+1) mod NUM_SIMD.
  - Latency: select is asserted in cycle T+1 for exactly one cycle. With no accept, simd_alu_select <= 0 and simd_sel_wfid holds its value.
- Done capture: simd_instr_done[i]=1 at an edge sets pending[i]<=1 and pend_wfid[i]<=the slice for SIMD i, and clears busy[i]. The SIMD becomes eligible again from the next cycle.
- Retire: each cycle, if any pending bit is set, select index r as the first pending bit from retire_ptr with wrap. At the edge: retire_valid<=1, retire_wfid<=pend_wfid[r], retire_simd<=r, pending[r]<=0, retire_ptr<=(r+1) mod NUM_SIMD. Otherwise retire_valid<=0.
  - Throughput: one retire per cycle.
  - Latency: done at edge E gives retire no earlier than the cycle after E+1.
- Simultaneous events:
  - Done capture and retire of the same index in one cycle: capture wins, so pending stays 1 with the new wfid.
  - Accept and done on different SIMDs in the same cycle are independent.
  - Done for a SIMD on the same edge it is granted cannot occur legally.
- Errors (protocol_err set, sticky until reset; the offending event is otherwise processed as above):
  - simd_instr_done[i] while busy[i]=0.
  - simd_instr_done[i] while pending[i]=1 and i is not being retired that cycle.
- With all SIMDs busy or not ready, issue_ready=0. Holding issue_valid with an unchanged issue_wfid is the issue stage's duty.

Test Plan:
- Reset, then all simd_alu_ready=1 and four back-to-back accepts with wfid 3,7,9,12 -> simd_alu_select = 0001,0010,0100,1000 in cycles T+1..T+4 carrying those wfids; busy=1111; issue_ready=0 in the next cycle.
- From the full-busy state, pulse simd_instr_done[2] with wfid 9 -> busy=1011; retire_valid with retire_wfid=9, retire_simd=2 two edges later; the next accept is granted to SIMD 2.
- Same-cycle done on SIMDs 0,1,3 (wfids 3,7,12) with retire_ptr=0 -> retires over three consecutive cycles in order simd 0,1,3; retire_valid is then 0.
- simd_alu_ready=0101, grant_ptr=1, accept wfid 20 -> grant goes to SIMD 2 and grant_ptr becomes 3.
- simd_instr_done[1] pulsed while busy[1]=0 -> protocol_err=1 and held; only rst clears it.
- Assert rst while busy=0110 and pending=0001 -> all outputs and state are 0 immediately (asynchronous); no retire occurs after deassertion.

Source files
------------

// File: rtl/simd_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : simd_issue_scheduler
//  Purpose  : Round-robin dispatch of ALU instructions to NUM_SIMD SIMD units
//             with one outstanding instruction per SIMD, and serialisation of
//             per-SIMD completions onto a single retire port.
//  Revision : 1.0  initial release
// ============================================================================
module simd_issue_scheduler #(
    parameter int NUM_SIMD = 4,
    parameter int SEL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [5:0]            issue_wfid,
    output logic                  issue_ready,
    input  logic [NUM_SIMD-1:0]   simd_alu_ready,
    output logic [NUM_SIMD-1:0]   simd_alu_select,
    output logic [5:0]            simd_sel_wfid,
    input  logic [NUM_SIMD-1:0]   simd_instr_done,
    input  logic [6*NUM_SIMD-1:0] simd_instr_done_wfid,
    output logic                  retire_valid,
    output logic [5:0]            retire_wfid,
    output logic [SEL_W-1:0]      retire_simd,
    output logic [NUM_SIMD-1:0]   busy,
    output logic                  protocol_err
);

    localparam logic [NUM_SIMD-1:0] c_one = {{(NUM_SIMD-1){1'b0}}, 1'b1};

    // Index arithmetic modulo NUM_SIMD (NUM_SIMD need not be a power of two).
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_SIMD) begin
            sum = sum - NUM_SIMD;
        end
        return SEL_W'(sum);
    endfunction

    logic [NUM_SIMD-1:0] r_select;
    logic [5:0]          r_sel_wfid;
    logic [NUM_SIMD-1:0] r_busy;
    logic [SEL_W-1:0]    r_grant_ptr;
    logic [NUM_SIMD-1:0] r_pending;
    logic [5:0]          r_pend_wfid [NUM_SIMD];
    logic [SEL_W-1:0]    r_retire_ptr;
    logic                r_retire_valid;
    logic [5:0]          r_retire_wfid;
    logic [SEL_W-1:0]    r_retire_simd;
    logic                r_protocol_err;

    logic [NUM_SIMD-1:0] w_elig;
    logic                w_accept;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [NUM_SIMD-1:0] w_grant_onehot;
    logic                w_retire_found;
    logic [SEL_W-1:0]    w_retire_idx;
    logic [NUM_SIMD-1:0] w_retire_clr;
    logic                w_err_event;

    // A SIMD is eligible when ready, idle, and not being selected right now.
    assign w_elig      = simd_alu_ready & ~r_busy & ~r_select;
    assign issue_ready = |w_elig;
    assign w_accept    = issue_valid & issue_ready;

    // Grant search: first eligible index from grant_ptr upward with wrap.
    // Scanning offsets high-to-low lets the smallest offset win.
    always_comb begin
        w_grant_idx = '0;
        for (int k = NUM_SIMD - 1; k >= 0; k--) begin
            if (w_elig[wrap_add(r_grant_ptr, k)]) begin
                w_grant_idx = wrap_add(r_grant_ptr, k);
            end
        end
    end

    assign w_grant_onehot = w_accept ? (c_one << w_grant_idx) : '0;

    // Retire search: first pending index from retire_ptr upward with wrap.
    always_comb begin
        w_retire_found = 1'b0;
        w_retire_idx   = '0;
        for (int k = NUM_SIMD - 1; k >= 0; k--) begin
            if (r_pending[wrap_add(r_retire_ptr, k)]) begin
                w_retire_found = 1'b1;
                w_retire_idx   = wrap_add(r_retire_ptr, k);
            end
        end
    end

    assign w_retire_clr = w_retire_found ? (c_one << w_retire_idx) : '0;

    // Done on an idle SIMD, or done on a SIMD whose previous completion is
    // still waiting and not leaving this cycle, would lose information.
    assign w_err_event = (|(simd_instr_done & ~r_busy)) |
                         (|(simd_instr_done & r_pending & ~w_retire_clr));

    // Issue side: one-cycle select pulse, wfid, busy tracking and grant pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_select    <= '0;
            r_sel_wfid  <= '0;
            r_busy      <= '0;
            r_grant_ptr <= '0;
        end else begin
            r_select <= w_grant_onehot;
            r_busy   <= (r_busy & ~simd_instr_done) | w_grant_onehot;
            if (w_accept) begin
                r_sel_wfid  <= issue_wfid;
                r_grant_ptr <= wrap_add(w_grant_idx, 1);
            end
        end
    end

    // Completion side: capture into pending (capture beats retire-clear),
    // then present one pending completion per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending      <= '0;
            r_retire_ptr   <= '0;
            r_retire_valid <= 1'b0;
            r_retire_wfid  <= '0;
            r_retire_simd  <= '0;
        end else begin
            r_pending      <= (r_pending & ~w_retire_clr) | simd_instr_done;
            r_retire_valid <= w_retire_found;
            if (w_retire_found) begin
                r_retire_wfid <= r_pend_wfid[w_retire_idx];
                r_retire_simd <= w_retire_idx;
                r_retire_ptr  <= wrap_add(w_retire_idx, 1);
            end
        end
    end

    // Per-SIMD completion wfid capture.
    for (genvar i = 0; i < NUM_SIMD; i++) begin : g_pend_wfid
        // Latch the SIMD's done wfid whenever it reports completion.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pend_wfid[i] <= '0;
            end else if (simd_instr_done[i]) begin
                r_pend_wfid[i] <= simd_instr_done_wfid[6*i +: 6];
            end
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_protocol_err <= 1'b0;
        end else begin
            r_protocol_err <= r_protocol_err | w_err_event;
        end
    end

    assign simd_alu_select = r_select;
    assign simd_sel_wfid   = r_sel_wfid;
    assign busy            = r_busy;
    assign retire_valid    = r_retire_valid;
    assign retire_wfid     = r_retire_wfid;
    assign retire_simd     = r_retire_simd;
    assign protocol_err    = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_simd_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simd_issue_scheduler
//  Purpose  : Directed self-checking bench for simd_issue_scheduler
//             (NUM_SIMD = 4) with hand-computed expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_simd_issue_scheduler;

    localparam int NUM_SIMD = 4;
    localparam int SEL_W    = 2;

    logic                  clk;
    logic                  rst;
    logic                  issue_valid;
    logic [5:0]            issue_wfid;
    logic                  issue_ready;
    logic [NUM_SIMD-1:0]   simd_alu_ready;
    logic [NUM_SIMD-1:0]   simd_alu_select;
    logic [5:0]            simd_sel_wfid;
    logic [NUM_SIMD-1:0]   simd_instr_done;
    logic [6*NUM_SIMD-1:0] simd_instr_done_wfid;
    logic                  retire_valid;
    logic [5:0]            retire_wfid;
    logic [SEL_W-1:0]      retire_simd;
    logic [NUM_SIMD-1:0]   busy;
    logic                  protocol_err;

    int checks = 0;
    int errors = 0;

    simd_issue_scheduler #(
        .NUM_SIMD (NUM_SIMD),
        .SEL_W    (SEL_W)
    ) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .issue_valid          (issue_valid),
        .issue_wfid           (issue_wfid),
        .issue_ready          (issue_ready),
        .simd_alu_ready       (simd_alu_ready),
        .simd_alu_select      (simd_alu_select),
        .simd_sel_wfid        (simd_sel_wfid),
        .simd_instr_done      (simd_instr_done),
        .simd_instr_done_wfid (simd_instr_done_wfid),
        .retire_valid         (retire_valid),
        .retire_wfid          (retire_wfid),
        .retire_simd          (retire_simd),
        .busy                 (busy),
        .protocol_err         (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_done(input int i, input logic [5:0] w);
        simd_instr_done[i]           = 1'b1;
        simd_instr_done_wfid[6*i +: 6] = w;
    endtask

    task automatic chk_retire(input string tag, input logic [5:0] w, input logic [1:0] s);
        chk({tag, "_v"}, 32'(retire_valid), 32'h1);
        chk({tag, "_w"}, 32'(retire_wfid), 32'(w));
        chk({tag, "_s"}, 32'(retire_simd), 32'(s));
    endtask

    task automatic chk_sel(input string tag, input logic [3:0] sel, input logic [5:0] w);
        chk({tag, "_sel"}, 32'(simd_alu_select), 32'(sel));
        chk({tag, "_wf"}, 32'(simd_sel_wfid), 32'(w));
    endtask

    initial begin
        logic [5:0] wf4 [4];
        logic [3:0] sel4 [4];

        rst                  = 1'b1;
        issue_valid          = 1'b0;
        issue_wfid           = '0;
        simd_alu_ready       = '0;
        simd_instr_done      = '0;
        simd_instr_done_wfid = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_sel", 32'(simd_alu_select), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rv", 32'(retire_valid), 32'h0);
        chk("rst_err", 32'(protocol_err), 32'h0);
        chk("rst_rdy", 32'(issue_ready), 32'h0);

        // Four back-to-back accepts with all SIMDs ready
        wf4  = '{6'd3, 6'd7, 6'd9, 6'd12};
        sel4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        simd_alu_ready = 4'b1111;
        issue_valid    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue_wfid = wf4[k];
            #1;
            chk("b2b_rdy", 32'(issue_ready), 32'h1);
            tick();
            chk_sel("b2b", sel4[k], wf4[k]);
        end
        chk("full_busy", 32'(busy), 32'hF);
        chk("full_rdy", 32'(issue_ready), 32'h0);
        issue_valid = 1'b0;

        // Simultaneous done on 0,1,3 with retire_ptr=0 -> retires 0,1,3
        set_done(0, 6'd3);
        set_done(1, 6'd7);
        set_done(3, 6'd12);
        tick();
        simd_instr_done = '0;
        chk("multi_busy", 32'(busy), 32'b0100);
        chk("multi_rv0", 32'(retire_valid), 32'h0);
        tick(); chk_retire("multi_r0", 6'd3, 2'd0);
        tick(); chk_retire("multi_r1", 6'd7, 2'd1);
        tick(); chk_retire("multi_r3", 6'd12, 2'd3);
        tick(); chk("multi_end", 32'(retire_valid), 32'h0);

        // Refill: SIMD 2 still busy, so grants go 0,1,3
        wf4  = '{6'd3, 6'd7, 6'd12, 6'd0};
        sel4 = '{4'b0001, 4'b0010, 4'b1000, 4'b0000};
        issue_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue_wfid = wf4[k];
            tick();
            chk_sel("refill", sel4[k], wf4[k]);
        end
        chk("refill_busy", 32'(busy), 32'hF);
        chk("refill_rdy", 32'(issue_ready), 32'h0);
        issue_valid = 1'b0;

        // Done on SIMD 2 from full-busy; retire two edges later; regrant to 2
        set_done(2, 6'd9);
        tick();
        simd_instr_done = '0;
        chk("d2_busy", 32'(busy), 32'b1011);
        chk("d2_rv0", 32'(retire_valid), 32'h0);
        tick();
        chk_retire("d2_ret", 6'd9, 2'd2);
        issue_valid = 1'b1;
        issue_wfid  = 6'd33;
        #1;
        chk("d2_rdy", 32'(issue_ready), 32'h1);
        tick();
        chk_sel("d2_regrant", 4'b0100, 6'd33);
        chk("d2_rv_end", 32'(retire_valid), 32'h0);
        issue_valid = 1'b0;

        // Release all four; retire_ptr=3 -> retire order 3,0,1,2
        set_done(0, 6'd3);
        set_done(1, 6'd7);
        set_done(2, 6'd33);
        set_done(3, 6'd12);
        tick();
        simd_instr_done = '0;
        chk("all_busy", 32'(busy), 32'h0);
        tick(); chk_retire("wrap_r3", 6'd12, 2'd3);
        tick(); chk_retire("wrap_r0", 6'd3, 2'd0);
        tick(); chk_retire("wrap_r1", 6'd7, 2'd1);
        tick(); chk_retire("wrap_r2", 6'd33, 2'd2);
        tick(); chk("wrap_end", 32'(retire_valid), 32'h0);

        // Move grant_ptr to 1 via a grant to SIMD 0 (scan from 3 wraps to 0)
        simd_alu_ready = 4'b0001;
        issue_valid    = 1'b1;
        issue_wfid     = 6'd40;
        tick();
        chk_sel("wrapgrant", 4'b0001, 6'd40);
        issue_valid = 1'b0;
        tick();
        chk("sel_pulse", 32'(simd_alu_select), 32'h0);
        chk("sel_hold", 32'(simd_sel_wfid), 32'd40);
        set_done(0, 6'd40);
        tick();
        simd_instr_done = '0;
        tick();
        chk_retire("r40", 6'd40, 2'd0);

        // ready=0101, grant_ptr=1 -> grant SIMD 2, then grant_ptr=3
        simd_alu_ready = 4'b0101;
        issue_valid    = 1'b1;
        issue_wfid     = 6'd20;
        #1;
        chk("rr_rdy", 32'(issue_ready), 32'h1);
        tick();
        chk_sel("rr_g2", 4'b0100, 6'd20);
        simd_alu_ready = 4'b1111;
        issue_wfid     = 6'd21;
        tick();
        chk_sel("rr_g3", 4'b1000, 6'd21);
        chk("rr_busy", 32'(busy), 32'b1100);
        issue_valid = 1'b0;
        chk("err_clean", 32'(protocol_err), 32'h0);

        // Done on idle SIMD 1 -> sticky protocol error
        set_done(1, 6'd5);
        tick();
        simd_instr_done = '0;
        chk("err_set", 32'(protocol_err), 32'h1);
        tick();
        chk_retire("err_ret", 6'd5, 2'd1);
        chk("err_hold1", 32'(protocol_err), 32'h1);
        tick();
        chk("err_hold2", 32'(protocol_err), 32'h1);
        chk("err_rv_end", 32'(retire_valid), 32'h0);

        // Build busy=0110 / pending=0001, then asynchronous reset
        simd_alu_ready = 4'b0011;
        issue_valid    = 1'b1;
        issue_wfid     = 6'd50;
        set_done(3, 6'd12);
        tick();
        simd_instr_done = '0;
        chk_sel("pre_g0", 4'b0001, 6'd50);
        chk("pre_busy0", 32'(busy), 32'b0101);
        issue_wfid = 6'd51;
        tick();
        chk_sel("pre_g1", 4'b0010, 6'd51);
        chk_retire("pre_r3", 6'd12, 2'd3);
        issue_valid = 1'b0;
        set_done(0, 6'd50);
        tick();
        simd_instr_done = '0;
        simd_alu_ready  = '0;
        chk("pre_busy", 32'(busy), 32'b0110);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_err", 32'(protocol_err), 32'h0);
        chk("arst_sel", 32'(simd_alu_select), 32'h0);
        chk("arst_swf", 32'(simd_sel_wfid), 32'h0);
        chk("arst_rv", 32'(retire_valid), 32'h0);
        chk("arst_rwf", 32'(retire_wfid), 32'h0);
        chk("arst_rs", 32'(retire_simd), 32'h0);
        chk("arst_rdy", 32'(issue_ready), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rv", 32'(retire_valid), 32'h0);
            chk("post_busy", 32'(busy), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
